capture_buf_ctrl: RTL and testbench
===================================

Name: capture_buf_ctrl

Overview:
- Sequences one-shot capture of 1-bit I/Q ADC samples into a pair of 36-bit-wide BSRAM sample buffers (I and Q).
- Synchronises the slow ADC clock and data into clk, packs 36 samples per word, and writes NUM_WORDS words.
- After capture, hands the buffer address port to the acquisition engine through a request/valid read interface.
- Sits between the ADC front-end pins and the acquisition correlator.

Parameters:
- NUM_WORDS, 112, words captured per run (112 x 36 = 4032 samples, about 1 ms at 4 MHz).
- ADDR_W, 14, BSRAM address width.
- WORD_W, 36, BSRAM data width and samples per word.

Ports:
- clk  in  1  system clock; all logic is clocked on posedge.
- rst  in  1  asynchronous, active-low reset.
- adc_clk  in  1  raw ADC sample clock, asynchronous to clk.
- i_in  in  1  raw I sample bit.
- q_in  in  1  raw Q sample bit.
- start  in  1  one-clk pulse that begins a capture.
- abort  in  1  one-clk pulse that cancels a capture.
- busy  out  1  high while capturing.
- done  out  1  high while the buffer holds a complete capture.
- mem_ad  out  ADDR_W  BSRAM address, shared by the I and Q buffers.
- mem_wre  out  1  BSRAM write enable.
- mem_di_i  out  WORD_W  packed I word.
- mem_di_q  out  WORD_W  packed Q word.
- mem_do_i  in  WORD_W  BSRAM I read data, valid 1 clk after mem_ad.
- mem_do_q  in  WORD_W  BSRAM Q read data, valid 1 clk after mem_ad.
- rd_req  in  1  read request from the acquisition engine.
- rd_addr  in  ADDR_W  word index to read.
- rd_valid  out  1  read data valid.
- rd_data_i  out  WORD_W  I read data.
- rd_data_q  out  WORD_W  Q read data.
- rd_err  out  1  one-clk pulse when a read request is rejected.

Behaviour:
- Reset (rst=0): all registers clear. busy=0, done=0, mem_wre=0, mem_ad=0, mem_di_*=0, rd_valid=0, rd_err=0. State goes to IDLE. This applies mid-capture too; mem_wre drops immediately.
- Synchronisers:
  - adc_clk, i_in and q_in each pass through a 2-flop register.
  - strobe = (stage0 of adc_clk sync) & ~(stage1 of adc_clk sync), i.e. a rising edge of adc_clk.
  - The sampled bits are stage1 of the i and q synchronisers on the strobe cycle.
- States:
  - IDLE: start -> CAPTURE.
  - CAPTURE: busy=1. After word NUM_WORDS-1 is written -> READY. abort -> IDLE.
  - READY: done=1. start -> CAPTURE. abort -> IDLE.
- Entering CAPTURE clears the bit counter, word address and shift registers, and sets done=0.
- Packing, on each strobe in CAPTURE:
  - shift_i <= {bit_i, shift_i[35:1]}; shift_q likewise.
  - The bit counter runs 0..35. When the counter equals 35 on a strobe, it resets to 0.
  - On the clk after that strobe: mem_wre=1 for exactly one clk, mem_ad=word index, mem_di_* = the completed words. The word index then increments.
  - So the first sample of each word lands in bit 0 and the newest in bit 35.
- Write latency: 1 clk after the strobe that completes the word.
- The transition to READY occurs on the clk after the final write; done rises in that same clk.
- Strobes in IDLE or READY are ignored; no write occurs.
- start while in CAPTURE is ignored.
- start and abort in the same clk: abort wins.
- abort arriving in the same clk as a pending write: the write is suppressed.
- Read port:
  - Reads are served only in READY.
  - A request is accepted when rd_req=1 and rd_addr < NUM_WORDS. The controller registers mem_ad <= rd_addr (cycle T+1); rd_valid=1 at T+2 with rd_data_* = mem_do_*.
  - One request can be accepted per clk, giving full throughput.
  - rd_req with rd_addr >= NUM_WORDS in READY: rd_err=1 at T+1, no access, rd_valid stays 0.
  - rd_req outside READY: rd_err=1 at T+1, no access.
  - Reads already in flight complete even if start moves the state to CAPTURE. No capture write can occur within 2 clks of start, because a word needs 36 strobes.
- Widths: the word index is ADDR_W bits and never exceeds NUM_WORDS-1; it does not wrap.
- mem_wre is never asserted outside CAPTURE.

Test Plan:
- Reset then start, with adc_clk = 20x clk period and I driven 1,0,1,0,... -> first write at mem_ad=0 with mem_di_i=36'hAAAAAAAAA (first sample in bit 0); mem_wre high exactly 1 clk.
- Full capture of 112 words with a random bitstream -> exactly 112 writes at addresses 0..111, words match the reference model, done=1 and busy=0 one clk after the last write.
- In READY, rd_req on back-to-back clks for addresses 5, 6, 111 -> rd_valid on three consecutive clks starting at T+2 with the matching data; then rd_addr=112 -> rd_err pulse and no rd_valid.
- abort after 50 words -> state IDLE, no further writes; subsequent rd_req -> rd_err.
- rst asserted mid-word during capture -> all outputs are zero at once; a new start restarts at address 0 with the bit counter at 0.
- start and abort in the same clk from READY -> IDLE, done=0, no capture.

Source files
------------

// File: rtl/capture_buf_ctrl_if.sv
// BSRAM port and acquisition-engine read port of the capture buffer controller.
// The controller takes the master side; the BSRAM/correlator environment takes the slave side.
interface capture_buf_ctrl_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned WORD_W = 36
);
  logic [ADDR_W-1:0] mem_ad;
  logic              mem_wre;
  logic [WORD_W-1:0] mem_di_i;
  logic [WORD_W-1:0] mem_di_q;
  logic [WORD_W-1:0] mem_do_i;
  logic [WORD_W-1:0] mem_do_q;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data_i;
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_err;

  modport master (
    output mem_ad, mem_wre, mem_di_i, mem_di_q,
    input  mem_do_i, mem_do_q,
    input  rd_req, rd_addr,
    output rd_valid, rd_data_i, rd_data_q, rd_err
  );

  modport slave (
    input  mem_ad, mem_wre, mem_di_i, mem_di_q,
    output mem_do_i, mem_do_q,
    output rd_req, rd_addr,
    input  rd_valid, rd_data_i, rd_data_q, rd_err
  );
endinterface

// File: rtl/capture_buf_ctrl.sv
// One-shot capture of synchronised 1-bit I/Q ADC samples into packed BSRAM words,
// followed by a pipelined read port for the acquisition engine once the buffer is full.
module capture_buf_ctrl #(
  parameter int unsigned NUM_WORDS = 112,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned WORD_W    = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_clk,
  input  logic              i_in,
  input  logic              q_in,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  capture_buf_ctrl_if.master bus
);

  localparam int unsigned       CntW      = $clog2(WORD_W);
  localparam logic [CntW-1:0]   LastBit   = CntW'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] NumWordsA = ADDR_W'(NUM_WORDS);

  typedef enum logic [1:0] {StIdle, StCapture, StReady} state_e;

  state_e state_q, state_d;
  logic   cap_start;

  logic [1:0] adc_sync_q, i_sync_q, q_sync_q;
  logic       strobe, bit_i, bit_q;

  logic [CntW-1:0]   bit_cnt_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [WORD_W-1:0] shift_i_q, shift_q_q, shift_i_nxt, shift_q_nxt;

  logic              mem_wre_q;
  logic [ADDR_W-1:0] mem_ad_q;
  logic [WORD_W-1:0] mem_di_i_q, mem_di_q_q;
  logic              rd_pend_q, rd_valid_q, rd_err_q;

  logic capturing, word_done, rd_acc;

  // Two-flop synchronisers; data bits share the adc_clk latency so stage1 holds the
  // level that was present just before the detected rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_sync_q <= '0;
      i_sync_q   <= '0;
      q_sync_q   <= '0;
    end else begin
      adc_sync_q <= {adc_sync_q[0], adc_clk};
      i_sync_q   <= {i_sync_q[0], i_in};
      q_sync_q   <= {q_sync_q[0], q_in};
    end
  end

  assign strobe = adc_sync_q[0] & ~adc_sync_q[1];
  assign bit_i  = i_sync_q[1];
  assign bit_q  = q_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cap_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StCapture;
          cap_start = 1'b1;
        end
      end
      StCapture: begin
        if (abort)                                  state_d = StIdle;
        else if (mem_wre_q && mem_ad_q == LastAddr) state_d = StReady;
      end
      StReady: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          state_d   = StCapture;
          cap_start = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign capturing   = (state_q == StCapture);
  assign busy        = capturing;
  assign done        = (state_q == StReady);
  assign shift_i_nxt = {bit_i, shift_i_q[WORD_W-1:1]};
  assign shift_q_nxt = {bit_q, shift_q_q[WORD_W-1:1]};
  // An abort in the strobe cycle cancels the write that strobe would have triggered.
  assign word_done   = capturing & strobe & (bit_cnt_q == LastBit) & ~abort;
  assign rd_acc      = (state_q == StReady) & bus.rd_req & (bus.rd_addr < NumWordsA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      shift_i_q  <= '0;
      shift_q_q  <= '0;
    end else if (cap_start) begin
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      shift_i_q  <= '0;
      shift_q_q  <= '0;
    end else if (capturing && strobe) begin
      shift_i_q <= shift_i_nxt;
      shift_q_q <= shift_q_nxt;
      bit_cnt_q <= (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + CntW'(1);
      if (word_done && word_idx_q != LastAddr) word_idx_q <= word_idx_q + ADDR_W'(1);
    end
  end

  // The address port is shared: capture writes in CAPTURE, read requests in READY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wre_q  <= 1'b0;
      mem_ad_q   <= '0;
      mem_di_i_q <= '0;
      mem_di_q_q <= '0;
    end else begin
      mem_wre_q <= word_done;
      if (word_done) begin
        mem_ad_q   <= word_idx_q;
        mem_di_i_q <= shift_i_nxt;
        mem_di_q_q <= shift_q_nxt;
      end else if (rd_acc) begin
        mem_ad_q <= bus.rd_addr;
      end
    end
  end

  // Reads already accepted finish regardless of later state changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_pend_q  <= rd_acc;
      rd_valid_q <= rd_pend_q;
      rd_err_q   <= bus.rd_req & ~rd_acc;
    end
  end

  assign bus.mem_wre   = mem_wre_q;
  assign bus.mem_ad    = mem_ad_q;
  assign bus.mem_di_i  = mem_di_i_q;
  assign bus.mem_di_q  = mem_di_q_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.rd_data_i = rd_valid_q ? bus.mem_do_i : '0;
  assign bus.rd_data_q = rd_valid_q ? bus.mem_do_q : '0;

endmodule

// File: tb/tb_capture_buf_ctrl.sv
// Self-checking bench for capture_buf_ctrl: random ADC bitstreams against a sample-list model,
// plus directed read, abort and reset scenarios.
module tb_capture_buf_ctrl;
  localparam int unsigned NUM_WORDS = 112;
  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned WORD_W    = 36;

  logic clk = 1'b0, rst = 1'b0, adc_clk = 1'b0, i_in = 1'b0, q_in = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic busy, done;

  capture_buf_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  capture_buf_ctrl #(.NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .adc_clk (adc_clk),
    .i_in    (i_in),
    .q_in    (q_in),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit rec = 1'b0;
  logic samp_i[$], samp_q[$];
  typedef struct packed {
    logic [ADDR_W-1:0] ad;
    logic [WORD_W-1:0] di_i;
    logic [WORD_W-1:0] di_q;
  } wr_t;
  wr_t wrs[$];
  logic [WORD_W-1:0] mem_i [0:127];
  logic [WORD_W-1:0] mem_q [0:127];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // BSRAM with one clock of read latency
  always @(posedge clk) begin
    if (bus.mem_wre) begin
      mem_i[bus.mem_ad[6:0]] <= bus.mem_di_i;
      mem_q[bus.mem_ad[6:0]] <= bus.mem_di_q;
    end
    bus.mem_do_i <= mem_i[bus.mem_ad[6:0]];
    bus.mem_do_q <= mem_q[bus.mem_ad[6:0]];
  end

  always @(negedge clk) begin
    if (bus.mem_wre) begin
      wrs.push_back({bus.mem_ad, bus.mem_di_i, bus.mem_di_q});
      check("wre_only_in_capture", busy, 1'b1);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Word n holds samples n*36 .. n*36+35, oldest in bit 0.
  function automatic logic [WORD_W-1:0] model_word(input int n, input bit use_q);
    logic [WORD_W-1:0] w = '0;
    for (int j = 0; j < int'(WORD_W); j++)
      w[j] = use_q ? samp_q[n*WORD_W+j] : samp_i[n*WORD_W+j];
    return w;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The ADC launches new data on its rising edge, so each edge samples the level held before it.
  task automatic adc_edge(input logic ni, input logic nq);
    if (rec) begin
      samp_i.push_back(i_in);
      samp_q.push_back(q_in);
    end
    adc_clk = 1'b1;
    i_in    = ni;
    q_in    = nq;
  endtask

  task automatic adc_cycle(input logic ni, input logic nq, input int half);
    adc_edge(ni, nq);
    clks(half);
    adc_clk = 1'b0;
    clks(half);
  endtask

  task automatic adc_rand(input int n, input int half);
    for (int k = 0; k < n; k++)
      adc_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), half);
  endtask

  task automatic wait_wre(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      seen = bus.mem_wre;
    end
    check({tag, "_wre_seen"}, seen, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    clks(1);
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},     busy,         1'b0);
    check({tag, "_done"},     done,         1'b0);
    check({tag, "_mem_wre"},  bus.mem_wre,  1'b0);
    check({tag, "_mem_ad"},   bus.mem_ad,   '0);
    check({tag, "_mem_di_i"}, bus.mem_di_i, '0);
    check({tag, "_mem_di_q"}, bus.mem_di_q, '0);
    check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
    check({tag, "_rd_err"},   bus.rd_err,   1'b0);
  endtask

  task automatic check_words(input string tag, input int n);
    check({tag, "_count"}, wrs.size(), n);
    for (int w = 0; w < n && w < wrs.size(); w++) begin
      check({tag, "_ad"},   wrs[w].ad,   w);
      check({tag, "_di_i"}, wrs[w].di_i, model_word(w, 1'b0));
      check({tag, "_di_q"}, wrs[w].di_q, model_word(w, 1'b1));
    end
  endtask

  initial begin
    int addrs[3] = '{5, 6, 111};
    wr_t w0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;

    clks(3);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    clks(2);

    // First word with slow adc_clk and I = 1,0,1,0,...
    rec = 1'b1;
    pulse_start();
    @(negedge clk);
    check("start_busy", busy, 1'b1);
    check("start_done", done, 1'b0);
    clks(1);
    for (int k = 0; k < 36; k++) adc_cycle(1'(k % 2 == 0), 1'($urandom_range(0, 1)), 10);
    check("w0_count", wrs.size(), 1);
    w0 = (wrs.size() > 0) ? wrs[0] : '0;
    check("w0_ad", w0.ad, 0);
    check("w0_di_i", w0.di_i, 36'hAAAAAAAAA);
    check("w0_di_q", w0.di_q, model_word(0, 1'b1));

    // Remainder of the capture with a random bitstream
    adc_rand(NUM_WORDS * WORD_W - 37, 3);
    adc_edge(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_wre("last");
    check("last_wr_busy", busy, 1'b1);
    check("last_wr_done", done, 1'b0);
    @(negedge clk);
    check("ready_done", done, 1'b1);
    check("ready_busy", busy, 1'b0);
    @(posedge clk); #1;
    adc_clk = 1'b0;
    clks(3);
    rec = 1'b0;
    check_words("full", NUM_WORDS);
    adc_rand(40, 3);
    check("ready_no_write", wrs.size(), NUM_WORDS);

    // Back-to-back reads
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = ADDR_W'(addrs[c]);
      end else begin
        bus.rd_req  = 1'b0;
      end
      @(negedge clk);
      check("rd_valid", bus.rd_valid, 1'(c >= 2 && c <= 4));
      check("rd_err_ok", bus.rd_err, 1'b0);
      if (c >= 2 && c <= 4) begin
        check("rd_data_i", bus.rd_data_i, model_word(addrs[c-2], 1'b0));
        check("rd_data_q", bus.rd_data_q, model_word(addrs[c-2], 1'b1));
      end
      @(posedge clk); #1;
    end

    // Out-of-range read
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_W'(NUM_WORDS);
    clks(1);
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("oor_err", bus.rd_err, 1'b1);
    check("oor_valid_t1", bus.rd_valid, 1'b0);
    clks(1);
    @(negedge clk);
    check("oor_err_clear", bus.rd_err, 1'b0);
    check("oor_valid_t2", bus.rd_valid, 1'b0);
    clks(1);

    // start and abort together from READY
    start = 1'b1;
    abort = 1'b1;
    clks(1);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("sa_busy", busy, 1'b0);
    check("sa_done", done, 1'b0);
    clks(1);
    adc_rand(40, 3);
    check("sa_no_write", wrs.size(), NUM_WORDS);
    check("sa_idle_busy", busy, 1'b0);

    // Abort landing on the strobe that completes word 50
    wrs.delete();
    samp_i.delete();
    samp_q.delete();
    rec = 1'b1;
    pulse_start();
    adc_rand(50 * WORD_W + 35, 3);
    adc_edge(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    clks(1);
    abort = 1'b1;
    clks(1);
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_wre_suppressed", bus.mem_wre, 1'b0);
    clks(2);
    adc_clk = 1'b0;
    clks(3);
    rec = 1'b0;
    adc_rand(40, 3);
    check_words("abort", 50);
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_W'(3);
    clks(1);
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("idle_rd_err", bus.rd_err, 1'b1);
    clks(1);
    @(negedge clk);
    check("idle_rd_valid", bus.rd_valid, 1'b0);
    clks(1);

    // Reset while a write is on the bus
    wrs.delete();
    pulse_start();
    adc_rand(2 * WORD_W - 1, 3);
    adc_edge(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_wre("rstwr");
    check("rstwr_ad", bus.mem_ad, 1);
    #1 rst = 1'b0;
    #1 check_zero("rst_mid");
    @(posedge clk); #1;
    adc_clk = 1'b0;
    clks(3);
    rst = 1'b1;
    clks(2);

    // Fresh capture after reset restarts at word 0, bit 0
    wrs.delete();
    samp_i.delete();
    samp_q.delete();
    rec = 1'b1;
    pulse_start();
    adc_rand(WORD_W, 3);
    check_words("restart", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
